// File: rtl/fusion_issue_ctrl_if.sv
// Fetch / fusion-decoder / issue-packet signals of fusion_issue_ctrl.
// master is the controller side, slave is the surrounding pipeline.
interface fusion_issue_ctrl_if;
    logic        fuse_en;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] dec_inst1;
    logic [31:0] dec_inst2;
    logic        fuse_flag;
    logic [1:0]  fuse_type;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_inst2;
    logic [31:0] id_pc;
    logic        id_fused;
    logic [1:0]  id_fuse_type;
    logic        id_ready;

    modport master (
        input  fuse_en, flush, if_valid, if_inst, if_pc, fuse_flag, fuse_type, id_ready,
        output if_ready, dec_inst1, dec_inst2, id_valid, id_inst, id_inst2, id_pc,
               id_fused, id_fuse_type
    );

    modport slave (
        output fuse_en, flush, if_valid, if_inst, if_pc, fuse_flag, fuse_type, id_ready,
        input  if_ready, dec_inst1, dec_inst2, id_valid, id_inst, id_inst2, id_pc,
               id_fused, id_fuse_type
    );
endinterface

// File: rtl/fusion_issue_ctrl.sv
// Fetch->Decode pairing window for macro-op fusion: buffers a head, issues fused/single packets.
// Define FUSION_PERF_EN to add the perf_fused_cnt / perf_issue_cnt counters.
module fusion_issue_ctrl #(
    parameter int          WAIT_MAX = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic clk,
    input  logic rst,
    fusion_issue_ctrl_if.master bus
`ifdef FUSION_PERF_EN
    ,
    output logic [31:0] perf_fused_cnt,
    output logic [31:0] perf_issue_cnt
`endif
);
    localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_HELD, ST_WAITING, ST_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   s_inst_q, s_inst_d, s_pc_q, s_pc_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          id_valid_q, id_valid_d, id_fused_q, id_fused_d;
    logic [31:0]   id_inst_q, id_inst_d, id_inst2_q, id_inst2_d, id_pc_q, id_pc_d;
    logic [1:0]    id_fuse_type_q, id_fuse_type_d;

    logic s_valid, advance, cand, fuse_ok, wait_ok;
    logic if_ready_c, load_s, issue_fused, issue_single, hold_wait;

    assign s_valid = (state_q == ST_HELD) || (state_q == ST_WAITING);
    assign advance = !id_valid_q || bus.id_ready;
    assign cand    = (s_inst_q[6:0] == 7'b0110111) || (s_inst_q[6:0] == 7'b0010111) ||
                     (s_inst_q[6:0] == 7'b0000011);
    // A fuse_type of 00 is not a real pairing even if the decoder raises the flag.
    assign fuse_ok = s_valid && bus.fuse_en && bus.fuse_flag && (bus.fuse_type != 2'b00) &&
                     bus.if_valid;
    assign wait_ok = s_valid && cand && bus.fuse_en && !bus.if_valid && (int'(wait_q) < WAIT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush)                        state_d = ST_EMPTY;
        else if (state_q == ST_DRAIN)         state_d = ST_DRAIN;
        else if (!advance) begin
            if (!s_valid && bus.if_valid)     state_d = ST_HELD;
        end
        else if (fuse_ok)                     state_d = (bus.fuse_type == 2'b10) ? ST_DRAIN : ST_EMPTY;
        else if (wait_ok)                     state_d = ST_WAITING;
        else                                  state_d = bus.if_valid ? ST_HELD : ST_EMPTY;
    end

    always_comb begin
        if_ready_c   = 1'b0;
        load_s       = 1'b0;
        issue_fused  = 1'b0;
        issue_single = 1'b0;
        hold_wait    = 1'b0;
        if (bus.flush) begin
            if_ready_c = 1'b0;
        end else if (state_q == ST_DRAIN) begin
            if_ready_c = 1'b1;
        end else if (!advance) begin
            if (!s_valid && bus.if_valid) begin
                load_s     = 1'b1;
                if_ready_c = 1'b1;
            end
        end else if (fuse_ok) begin
            issue_fused = 1'b1;
            if_ready_c  = 1'b1;
        end else if (wait_ok) begin
            hold_wait = 1'b1;
        end else begin
            issue_single = s_valid;
            if (bus.if_valid) begin
                load_s     = 1'b1;
                if_ready_c = 1'b1;
            end
        end
    end

    assign bus.if_ready     = if_ready_c && !rst;
    assign bus.dec_inst1    = s_valid ? s_inst_q : NOP_INST;
    assign bus.dec_inst2    = bus.if_valid ? bus.if_inst : NOP_INST;
    assign bus.id_valid     = id_valid_q;
    assign bus.id_inst      = id_inst_q;
    assign bus.id_inst2     = id_inst2_q;
    assign bus.id_pc        = id_pc_q;
    assign bus.id_fused     = id_fused_q;
    assign bus.id_fuse_type = id_fuse_type_q;

    always_comb begin
        s_inst_d       = load_s ? bus.if_inst : s_inst_q;
        s_pc_d         = load_s ? bus.if_pc : s_pc_q;
        wait_d         = wait_q;
        if (hold_wait)
            wait_d = wait_q + WW'(1);
        else if (bus.flush || load_s || issue_fused || issue_single)
            wait_d = '0;
        id_valid_d     = (issue_fused || issue_single) ? 1'b1 : (advance ? 1'b0 : id_valid_q);
        id_inst_d      = id_inst_q;
        id_inst2_d     = id_inst2_q;
        id_pc_d        = id_pc_q;
        id_fused_d     = id_fused_q;
        id_fuse_type_d = id_fuse_type_q;
        if (issue_fused || issue_single) begin
            id_inst_d      = s_inst_q;
            id_pc_d        = s_pc_q;
            id_inst2_d     = issue_fused ? bus.if_inst : NOP_INST;
            id_fused_d     = issue_fused;
            id_fuse_type_d = issue_fused ? bus.fuse_type : 2'b00;
        end
        if (bus.flush) id_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_inst_q       <= NOP_INST;
            s_pc_q         <= '0;
            wait_q         <= '0;
            id_valid_q     <= 1'b0;
            id_inst_q      <= NOP_INST;
            id_inst2_q     <= NOP_INST;
            id_pc_q        <= '0;
            id_fused_q     <= 1'b0;
            id_fuse_type_q <= 2'b00;
        end else begin
            s_inst_q       <= s_inst_d;
            s_pc_q         <= s_pc_d;
            wait_q         <= wait_d;
            id_valid_q     <= id_valid_d;
            id_inst_q      <= id_inst_d;
            id_inst2_q     <= id_inst2_d;
            id_pc_q        <= id_pc_d;
            id_fused_q     <= id_fused_d;
            id_fuse_type_q <= id_fuse_type_d;
        end
    end

`ifdef FUSION_PERF_EN
    // Counters follow packet loads only; flush never rewinds them.
    logic [31:0] perf_fused_cnt_q, perf_fused_cnt_d, perf_issue_cnt_q, perf_issue_cnt_d;

    always_comb begin
        perf_fused_cnt_d = perf_fused_cnt_q + {31'd0, issue_fused};
        perf_issue_cnt_d = perf_issue_cnt_q + {31'd0, issue_fused || issue_single};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fused_cnt_q <= '0;
            perf_issue_cnt_q <= '0;
        end else begin
            perf_fused_cnt_q <= perf_fused_cnt_d;
            perf_issue_cnt_q <= perf_issue_cnt_d;
        end
    end

    assign perf_fused_cnt = perf_fused_cnt_q;
    assign perf_issue_cnt = perf_issue_cnt_q;
`endif
endmodule

// File: doc/fusion_issue_ctrl.md
# fusion_issue_ctrl

Sequencing controller between the Fetch and Decode stages that owns the pairing window for macro-op fusion. It buffers one fetched instruction as a fusion head, presents head and next-fetched instruction to the combinational fusion decoder, and issues either a fused pair or a single instruction into the ID pipeline register under a valid/ready handshake. It also briefly holds fusable heads to wait for a partner, and discards the sequential fall-through after a fused AUIPC+JALR until the redirect flush arrives.

## Interface
- `WAIT_MAX`, 2: max cycles a fusable head is held waiting for a partner (0 disables waiting).
- `NOP_INST`, 32'h00000013: bubble encoding.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fuse_en` in 1: runtime fusion enable.
- `if_valid` in 1 / `if_inst` in 32 / `if_pc` in 32: fetch output.
- `if_ready` out 1: fetch word is consumed this cycle.
- `dec_inst1` out 32: head to fusion decoder inst1 (NOP_INST when buffer empty).
- `dec_inst2` out 32: to fusion decoder inst2 (`if_inst` when `if_valid`, else NOP_INST).
- `fuse_flag` in 1 / `fuse_type` in 2: fusion decoder result (01 LUI+ADDI, 10 AUIPC+JALR, 11 LOAD+ALU).
- `id_valid` out 1 / `id_inst` out 32 / `id_inst2` out 32 / `id_pc` out 32 / `id_fused` out 1 / `id_fuse_type` out 2: registered issue packet.
- `id_ready` in 1: decode accepts packet.
- `flush` in 1: pipeline redirect; kills buffer and packet.

## Operation
- Internal head buffer S: valid, inst, pc, wait counter (width clog2(WAIT_MAX+1)).
- Head candidate: S opcode is LUI (0110111), AUIPC (0010111) or LOAD (0000011).
- advance = !id_valid || id_ready.
- FSM states: EMPTY, HELD (S valid, wait=0), WAITING (S valid, wait>0), DRAIN.
- Per cycle, priority top-down:
  - flush: S, packet invalid; state EMPTY; if_ready=0.
  - DRAIN: if_ready=1, fetched words discarded; packet drains normally; stay until flush.
  - !advance: packet holds; if S empty and if_valid, load S (if_ready=1); else if_ready=0.
  - S valid, fuse_en, fuse_flag, if_valid: issue fused packet (id_inst=S.inst, id_inst2=if_inst, id_pc=S.pc, id_fused=1, id_fuse_type=fuse_type); if_ready=1; S empties. fuse_type 10 -> DRAIN, else EMPTY.
  - S valid, candidate, fuse_en, !if_valid, wait<WAIT_MAX: hold S, wait++, state WAITING; id_valid <= 0.
  - S valid otherwise: issue single (id_fused=0, id_fuse_type=00, id_inst2=NOP_INST); S <= if_inst/if_pc when if_valid (if_ready=1, wait=0, HELD), else EMPTY.
  - S empty: S <= fetch word if if_valid (if_ready=1); id_valid <= 0.
- fuse_flag ignored when fuse_en=0 or S invalid; fuse_type 00 with fuse_flag=1 treated as no fusion.
- Clearing fuse_en mid-WAITING: next cycle issues S single.

## Timing
- Reset: id_valid=0, id_fused=0, id_fuse_type=00, id_pc=0, id_inst=id_inst2=NOP_INST, state EMPTY, S invalid, wait=0; if_ready=0 while rst high.
- if_ready, dec_inst1, dec_inst2 combinational from state/S/inputs; no combinational path from fuse_flag to fuse_flag.
- Latency: word accepted at edge N appears on id_* after edge N+1 (non-candidate or partner present).
- Throughput: one packet per cycle; a fused packet consumes two instructions in one issue.
- Held head issues single no later than WAIT_MAX+1 cycles after entering S with no fetch.
- Packet stable while id_valid && !id_ready.
- flush during held packet or DRAIN: id_valid=0 after next edge.

## Configuration
- `FUSION_PERF_EN` defined: adds outputs `perf_fused_cnt` out 32 (fused packets issued) and `perf_issue_cnt` out 32 (all packets issued); increment on packet load, wrap at 2^32, cleared by rst only, unaffected by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- LUI x5,0x12345 then ADDI x5,x5,0x678 back-to-back, fuse_flag=1/type 01 -> one packet, id_fused=1, id_inst2=ADDI, id_pc=LUI pc.
- LUI head, if_valid low 2 cycles (WAIT_MAX=2), ADDI on cycle 3 -> fused; with gap of 3 -> LUI issues single, ADDI single after.
- AUIPC+JALR fused, then 3 sequential fetches, flush on 4th cycle -> fetches discarded, if_ready=1, no id_valid until post-flush word.
- ADD, SUB, ADD stream with id_ready low 3 cycles mid-stream -> packet held stable, no loss/duplication, 1/cycle resumes.
- fuse_en=0 with LW+ADD dependent pair, fuse_flag=1 -> two single packets, no wait cycles.
- rst asserted asynchronously while WAITING -> outputs to reset values immediately; perf counters (FUSION_PERF_EN) read 0.
